// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, single-outstanding imem request, and a
// registered instruction handed downstream. Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] fetch_count,
  output logic        fetch_err,
  output logic [1:0]  fsm_state
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_OUT = 2'd2, S_ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_OUT = 2'd2} state_t;
`endif

  // Handshakes: imem transfer completes on a cycle with imem_req && imem_rvalid;
  // downstream transfer completes on a cycle with instr_valid && instr_ready.
  state_t state, state_next;
  logic   handoff;
  logic   trap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    handoff    = 1'b0;
    trap       = 1'b0;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (imem_rvalid) state_next = S_OUT;
      S_OUT: begin
        if (instr_ready) begin
          handoff    = 1'b1;
          state_next = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (branch_taken && (branch_target[1:0] != 2'b00)) begin
            trap       = 1'b1;
            state_next = S_ERR;
          end
`endif
        end
      end
      default: state_next = state;
    endcase
  end

  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_OUT);
  assign imem_addr   = pc;
  assign opcode      = instr[6:0];
  assign pc_plus4    = pc + 32'd4;
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= NOP;
      fetch_count <= '0;
    end else begin
      if ((state == S_FETCH) && imem_rvalid) instr <= imem_rdata;
      if (handoff) begin
        fetch_count <= fetch_count + 32'd1;
        // Redirects are forced word-aligned; a trapped redirect leaves pc alone.
        if (!trap) pc <= branch_taken ? (branch_target & ~32'h3) : pc_plus4;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fetch_err <= 1'b0;
    else if (trap) fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule
